// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared constants for the WS2812B frame sequencer
package led_pkg;

  localparam int PIXEL_W        = 24;
  localparam int RET_CYCLES_DEF = 6000;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_SEND  = 3'd3;
  localparam logic [2:0] ST_RET   = 3'd4;

  localparam logic [1:0] GEN_LOW  = 2'b00;
  localparam logic [1:0] GEN_ZERO = 2'b10;
  localparam logic [1:0] GEN_ONE  = 2'b11;

  // Width of a down-counter that is loaded with n-1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_frame_sequencer_if.sv
// rtl/led_frame_sequencer_if.sv - requester, pixel buffer and bit generator signals
interface led_frame_sequencer_if #(
  parameter int ADDR_W = 3
);
  import led_pkg::*;

  logic                 frameReq;
  logic                 busy;
  logic                 frameDone;
  logic                 retActive;
  logic                 pixRd;
  logic [ADDR_W-1:0]    pixAddr;
  logic [PIXEL_W-1:0]   pixData;
  logic [1:0]           genMode;
  logic                 genDone;

  modport master (
    input  frameReq, pixData, genDone,
    output busy, frameDone, retActive, pixRd, pixAddr, genMode
  );

  modport slave (
    output frameReq, pixData, genDone,
    input  busy, frameDone, retActive, pixRd, pixAddr, genMode
  );

endinterface

// File: rtl/led_ret_timer.sv
// rtl/led_ret_timer.sv - loadable down-counter; o_done marks the last active cycle
module led_ret_timer #(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_active,
  output logic             o_done
);

  logic [WIDTH-1:0] r_cnt;
  logic             r_active;

  // A load of N-1 keeps the timer active for exactly N cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (i_load) begin
      r_cnt    <= i_load_val;
      r_active <= 1'b1;
    end else if (r_active) begin
      if (r_cnt == '0) begin
        r_active <= 1'b0;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign o_active = r_active;
  assign o_done   = r_active && (r_cnt == '0);

endmodule

// File: rtl/led_frame_sequencer.sv
// rtl/led_frame_sequencer.sv - gapless prefetching WS2812B frame scheduler
// LED_AUTO_REFRESH_EN adds a periodic internal frame request.
module led_frame_sequencer
  import led_pkg::*;
#(
  parameter int NUM_LEDS       = 8,
  parameter int ADDR_W         = 3,
  parameter int RET_CYCLES     = RET_CYCLES_DEF,
  parameter int REFRESH_CYCLES = 1666667
) (
  input  logic                  clk,
  input  logic                  reset,
  led_frame_sequencer_if.master bus
);

  localparam int IDX_W = ADDR_W + 1;
  localparam int RET_W = cnt_width(RET_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);

  if (NUM_LEDS < 1 || NUM_LEDS > (1 << ADDR_W) || RET_CYCLES < 1 || REFRESH_CYCLES < 2) begin : g_bad_params
    $error("led_frame_sequencer: parameter out of range");
  end

  logic [2:0]         r_state;
  logic [PIXEL_W-1:0] r_shift;
  logic [PIXEL_W-1:0] r_shadow;
  logic [4:0]         r_bit_cnt;
  logic [IDX_W-1:0]   r_pix_idx;
  logic               r_pix_rd;
  logic               r_rd_q;
  logic [ADDR_W-1:0]  r_pix_addr;
  logic               r_pending;
  logic               r_frame_done;

  logic               w_req;
  logic               w_refresh_req;
  logic               w_bit_done;
  logic               w_pix_end;
  logic               w_more;
  logic               w_frame_end;
  logic [IDX_W-1:0]   w_next_pf_idx;
  logic               w_pf_ok;
  logic               w_ret_active;
  logic               w_ret_done;

`ifdef LED_AUTO_REFRESH_EN
  localparam int REF_W = cnt_width(REFRESH_CYCLES);
  logic w_ref_active;
  logic w_ref_done;

  led_ret_timer #(.WIDTH(REF_W)) u_refresh (
    .clk        (clk),
    .rst_n      (reset),
    .i_load     (w_ref_done | ~w_ref_active),
    .i_load_val (REF_W'(REFRESH_CYCLES - 1)),
    .o_active   (w_ref_active),
    .o_done     (w_ref_done)
  );
  assign w_refresh_req = w_ref_done;
`else
  assign w_refresh_req = 1'b0;
`endif

  assign w_req         = bus.frameReq | w_refresh_req;
  assign w_bit_done    = (r_state == ST_SEND) && bus.genDone;
  assign w_pix_end     = w_bit_done && (r_bit_cnt == 5'd23);
  assign w_more        = r_pix_idx < LAST_IDX;
  assign w_frame_end   = w_pix_end && !w_more;
  assign w_next_pf_idx = r_pix_idx + IDX_W'(2);
  assign w_pf_ok       = w_next_pf_idx <= LAST_IDX;

  led_ret_timer #(.WIDTH(RET_W)) u_ret (
    .clk        (clk),
    .rst_n      (reset),
    .i_load     (w_frame_end),
    .i_load_val (RET_W'(RET_CYCLES - 1)),
    .o_active   (w_ret_active),
    .o_done     (w_ret_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_shadow     <= '0;
      r_bit_cnt    <= '0;
      r_pix_idx    <= '0;
      r_pix_rd     <= 1'b0;
      r_rd_q       <= 1'b0;
      r_pix_addr   <= '0;
      r_pending    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_pix_rd     <= 1'b0;
      r_frame_done <= 1'b0;
      r_rd_q       <= r_pix_rd;
      if (w_req && r_state != ST_IDLE) r_pending <= 1'b1;
      // Prefetched pixel lands one cycle after its read strobe.
      if (r_rd_q && r_state == ST_SEND) r_shadow <= bus.pixData;

      case (r_state)
        ST_IDLE: begin
          if (w_req || r_pending) begin
            r_pending  <= 1'b0;
            r_pix_addr <= '0;
            r_pix_rd   <= 1'b1;
            r_state    <= ST_FETCH;
          end
        end
        ST_FETCH: r_state <= ST_LOAD;
        ST_LOAD: begin
          r_shift   <= bus.pixData;
          r_bit_cnt <= '0;
          r_pix_idx <= '0;
          if (NUM_LEDS > 1) begin
            r_pix_addr <= ADDR_W'(1);
            r_pix_rd   <= 1'b1;
          end
          r_state <= ST_SEND;
        end
        ST_SEND: begin
          if (w_pix_end) begin
            if (w_more) begin
              r_shift   <= r_shadow;
              r_pix_idx <= r_pix_idx + IDX_W'(1);
              r_bit_cnt <= '0;
              if (w_pf_ok) begin
                r_pix_addr <= w_next_pf_idx[ADDR_W-1:0];
                r_pix_rd   <= 1'b1;
              end
            end else begin
              r_state <= ST_RET;
            end
          end else if (w_bit_done) begin
            r_shift   <= {r_shift[PIXEL_W-2:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + 5'd1;
          end
        end
        ST_RET: begin
          if (w_ret_done) begin
            r_state      <= ST_IDLE;
            r_frame_done <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.frameDone = r_frame_done;
  assign bus.retActive = w_ret_active;
  assign bus.pixRd     = r_pix_rd;
  assign bus.pixAddr   = r_pix_addr;
  assign bus.genMode   = (r_state == ST_SEND) ? (r_shift[PIXEL_W-1] ? GEN_ONE : GEN_ZERO) : GEN_LOW;

endmodule

// File: tb/tb_led_frame_sequencer.sv
// tb/tb_led_frame_sequencer.sv - randomized self-checking bench for led_frame_sequencer
module tb_led_frame_sequencer;
  import led_pkg::*;

  localparam int RET     = 6000;
  localparam int REFRESH = 20000;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  led_frame_sequencer_if #(.ADDR_W(3)) if_a ();
  led_frame_sequencer_if #(.ADDR_W(3)) if_b ();

  led_frame_sequencer #(.NUM_LEDS(2), .ADDR_W(3), .RET_CYCLES(RET), .REFRESH_CYCLES(REFRESH)) dut_a (
    .clk(clk), .reset(rst_n), .bus(if_a)
  );
  led_frame_sequencer #(.NUM_LEDS(1), .ADDR_W(3), .RET_CYCLES(RET), .REFRESH_CYCLES(REFRESH)) dut_b (
    .clk(clk), .reset(rst_n), .bus(if_b)
  );

  logic [23:0] mem [8];
  logic [23:0] pd_a, pd_b;
  int          period = 8;
  int          cnt_a = 0, cnt_b = 0;
  logic        sel = 1'b0, req = 1'b0, gforce = 1'b0;
  int          compared = 0, mismatched = 0;
  int          done_cnt = 0;
  logic [2:0]  rd_q [$];

  // Environment: pixel buffer with one-cycle read latency and a bit generator of fixed period.
  assign if_a.frameReq = req & ~sel;
  assign if_b.frameReq = req & sel;
  assign if_a.pixData  = pd_a;
  assign if_b.pixData  = pd_b;
  assign if_a.genDone  = (if_a.genMode[1] && cnt_a == period - 1) || (gforce && !sel);
  assign if_b.genDone  = (if_b.genMode[1] && cnt_b == period - 1) || (gforce && sel);

  always @(posedge clk) begin
    if (if_a.pixRd) pd_a <= mem[if_a.pixAddr];
    if (if_b.pixRd) pd_b <= mem[if_b.pixAddr];
    cnt_a <= if_a.genMode[1] ? ((cnt_a == period - 1) ? 0 : cnt_a + 1) : 0;
    cnt_b <= if_b.genMode[1] ? ((cnt_b == period - 1) ? 0 : cnt_b + 1) : 0;
  end

  logic [1:0] mon_mode;
  logic [2:0] mon_addr;
  logic       mon_busy, mon_done, mon_ret, mon_rd;
  assign mon_mode = sel ? if_b.genMode   : if_a.genMode;
  assign mon_addr = sel ? if_b.pixAddr   : if_a.pixAddr;
  assign mon_busy = sel ? if_b.busy      : if_a.busy;
  assign mon_done = sel ? if_b.frameDone : if_a.frameDone;
  assign mon_ret  = sel ? if_b.retActive : if_a.retActive;
  assign mon_rd   = sel ? if_b.pixRd     : if_a.pixRd;

  always @(negedge clk) begin
    if (mon_rd) rd_q.push_back(mon_addr);
    if (mon_done) done_cnt++;
  end

  task automatic pulse_req();
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 8; i++) mem[i] = 24'($urandom);
  endtask

  // Expected stream: each pixel's bits MSB first, each held one bit period, then RET low, then frameDone.
  task automatic check_frame(input string tag, input int n, input bit spur, input bit extra, input int base);
    int t, errs, ret_len, ret_errs, bitn;
    t = 0;
    while (mon_mode == GEN_LOW && t < 20) begin
      @(negedge clk);
      t++;
    end
    compared++;
    if (mon_mode == GEN_LOW) begin
      mismatched++;
      $display("FAIL %s start: genMode=%b, required a send code within 20 clks", tag, mon_mode);
      return;
    end
    errs = 0;
    for (int i = 0; i < n; i++)
      for (int b = 23; b >= 0; b--)
        for (int c = 0; c < period; c++) begin
          bitn = i * 24 + (23 - b);
          req = extra && c == 1 && (bitn == 5 || bitn == 20 || bitn == 40);
          if (mon_mode !== {1'b1, mem[i][b]}) errs++;
          @(negedge clk);
        end
    req = 1'b0;
    compared++;
    if (errs != 0) begin
      mismatched++;
      $display("FAIL %s stream: %0d wrong genMode cycles, required 0", tag, errs);
    end
    ret_len = 0;
    ret_errs = 0;
    while (mon_ret === 1'b1 && ret_len < RET + 100) begin
      if (mon_mode !== GEN_LOW || mon_busy !== 1'b1) ret_errs++;
      gforce = spur && (ret_len % 1500 == 7);
      ret_len++;
      @(negedge clk);
    end
    gforce = 1'b0;
    compared++;
    if (ret_len != RET) begin
      mismatched++;
      $display("FAIL %s ret_len: got %0d, required %0d", tag, ret_len, RET);
    end
    compared++;
    if (ret_errs != 0) begin
      mismatched++;
      $display("FAIL %s ret_state: %0d cycles not low/busy, required 0", tag, ret_errs);
    end
    compared++;
    if (mon_done !== 1'b1 || mon_busy !== 1'b0) begin
      mismatched++;
      $display("FAIL %s done: frameDone=%b busy=%b, required 1/0", tag, mon_done, mon_busy);
    end
    errs = 0;
    if (rd_q.size() - base != n) errs++;
    else for (int i = 0; i < n; i++) if (rd_q[base + i] != 3'(i)) errs++;
    compared++;
    if (errs != 0) begin
      mismatched++;
      $display("FAIL %s reads: %0d reads with %0d bad, required %0d in order", tag, rd_q.size() - base, errs, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if (if_a.busy !== 1'b0 || if_a.frameDone !== 1'b0 || if_a.retActive !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_flags: busy=%b done=%b ret=%b, required 000", if_a.busy, if_a.frameDone, if_a.retActive);
    end
    compared++;
    if (if_a.pixRd !== 1'b0 || if_a.pixAddr !== 3'd0) begin
      mismatched++;
      $display("FAIL reset_read: pixRd=%b pixAddr=%0d, required 0/0", if_a.pixRd, if_a.pixAddr);
    end
    compared++;
    if (if_a.genMode !== GEN_LOW || if_b.genMode !== GEN_LOW) begin
      mismatched++;
      $display("FAIL reset_mode: genMode=%b/%b, required 00", if_a.genMode, if_b.genMode);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_two_pixel();
    int base;
    period = 125;
    mem[0] = 24'hFF0000;
    mem[1] = 24'h00000F;
    base = rd_q.size();
    pulse_req();
    check_frame("two_pixel", 2, 1'b0, 1'b0, base);
  endtask

  task automatic test_single_led();
    int base;
    sel = 1'b1;
    period = $urandom_range(3, 10);
    mem[0] = 24'hA5A5A5;
    @(negedge clk);
    base = rd_q.size();
    pulse_req();
    check_frame("single_led", 1, 1'b0, 1'b0, base);
    @(negedge clk);
    sel = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int base, d0;
    period = $urandom_range(3, 10);
    fill_mem();
    d0 = done_cnt;
    base = rd_q.size();
    pulse_req();
    check_frame("pend_first", 2, 1'b0, 1'b1, base);
    base = rd_q.size();
    @(negedge clk);
    compared++;
    if (mon_busy !== 1'b1) begin
      mismatched++;
      $display("FAIL pend_restart: busy=%b one clk after frameDone, required 1", mon_busy);
    end
    check_frame("pend_second", 2, 1'b0, 1'b0, base);
    repeat (30) @(negedge clk);
    compared++;
    if (done_cnt - d0 != 2 || mon_busy !== 1'b0) begin
      mismatched++;
      $display("FAIL pend_total: %0d frameDone pulses busy=%b, required 2 and 0", done_cnt - d0, mon_busy);
    end
  endtask

  task automatic test_spurious();
    int base;
    logic [2:0] addr0;
    addr0 = mon_addr;
    base = rd_q.size();
    for (int k = 0; k < 3; k++) begin
      gforce = 1'b1;
      @(negedge clk);
      gforce = 1'b0;
      @(negedge clk);
    end
    compared++;
    if (mon_busy !== 1'b0 || mon_addr !== addr0 || mon_mode !== GEN_LOW || rd_q.size() != base) begin
      mismatched++;
      $display("FAIL spur_idle: busy=%b addr=%0d mode=%b reads=%0d, required 0/%0d/00/0",
               mon_busy, mon_addr, mon_mode, rd_q.size() - base, addr0);
    end
    period = $urandom_range(3, 10);
    fill_mem();
    base = rd_q.size();
    pulse_req();
    check_frame("spur_ret", 2, 1'b1, 1'b0, base);
  endtask

  task automatic test_reset_mid_frame();
    int t, base;
    period = $urandom_range(4, 10);
    fill_mem();
    pulse_req();
    t = 0;
    while (mon_mode == GEN_LOW && t < 20) begin
      @(negedge clk);
      t++;
    end
    repeat ((24 + 10) * period + period / 2) @(negedge clk);
    compared++;
    if (mon_mode !== {1'b1, mem[1][13]}) begin
      mismatched++;
      $display("FAIL midrst_pre: genMode=%b, required %b", mon_mode, {1'b1, mem[1][13]});
    end
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if (mon_mode !== GEN_LOW || mon_busy !== 1'b0) begin
      mismatched++;
      $display("FAIL midrst_async: genMode=%b busy=%b, required 00/0", mon_mode, mon_busy);
    end
    compared++;
    if (mon_addr !== 3'd0) begin
      mismatched++;
      $display("FAIL midrst_addr: pixAddr=%0d, required 0", mon_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    fill_mem();
    base = rd_q.size();
    pulse_req();
    check_frame("after_reset", 2, 1'b0, 1'b0, base);
  endtask

  task automatic test_random_frames();
    int base;
    for (int k = 0; k < 2; k++) begin
      period = $urandom_range(2, 12);
      fill_mem();
      repeat ($urandom_range(1, 5)) @(negedge clk);
      base = rd_q.size();
      pulse_req();
      check_frame("random", 2, 1'b0, 1'b0, base);
    end
  endtask

  task automatic test_refresh();
    int t;
    period = 3;
    for (int k = 0; k < 3; k++) begin
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (mon_done !== 1'b1 && t < 2 * REFRESH);
      if (k > 0) begin
        compared++;
        if (t != REFRESH) begin
          mismatched++;
          $display("FAIL refresh_gap: %0d clks between frameDone pulses, required %0d", t, REFRESH);
        end
      end
    end
  endtask

  initial begin
    test_reset();
`ifdef LED_AUTO_REFRESH_EN
    test_refresh();
`else
    test_two_pixel();
    test_single_led();
    test_back_to_back();
    test_spurious();
    test_reset_mid_frame();
    test_random_frames();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish within 300000 clks");
    $fatal(1, "watchdog");
  end

endmodule
